instruction_loader: RTL and testbench
=====================================

// Module: instruction_loader
// PURPOSE
//  Writer side of the instruction-memory load port. Takes the byte stream from the debug UART
//  receiver, packs 4 bytes MSB-first into 32-bit instructions and writes them to consecutive
//  word addresses of the fetch-stage ROM. Stops after the HALT word (0xFFFFFFFF) is written.
//  o_busy is used at top level to deassert the pipeline enable while a load is in progress.
// PARAMETERS
//  NB_BYTE     8             width of one received byte
//  NB_INSTR    32            instruction width; must equal 4*NB_BYTE
//  NB_PC       32            width of the write address (word address, +1 per instruction)
//  N_WORDS     1024          instruction memory depth; limit for program size
//  HALT_INSTR  32'hFFFFFFFF  end-of-program word; written to memory, then the load ends
// PORTS
//  i_clk                    in   1         clock
//  i_rst                    in   1         synchronous, active-high reset
//  i_start                  in   1         1-cycle pulse: begin (or restart) a load at address 0
//  i_rx_data                in   NB_BYTE   received byte
//  i_rx_valid               in   1         1-cycle strobe: i_rx_data valid
//  o_instruction_write_enb  out  1         memory write enable; 1-cycle pulse per word
//  o_instruction_addr       out  NB_PC     memory write word address
//  o_instruction_data       out  NB_INSTR  memory write data
//  o_busy                   out  1         high in RECV and WRITE
//  o_done                   out  1         level; HALT written, load complete
//  o_overflow               out  1         level; N_WORDS filled without a HALT
//  o_word_count             out  NB_PC     words written in this load, HALT included
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; byte counter, shift register and address counter cleared.
//    Reset during a load abandons it; words already written stay in memory.
//  - States: IDLE, RECV, WRITE, DONE, ERROR.
//  - i_start from any state: go to RECV; addr=0, byte_cnt=0, word_count=0; clear done/overflow.
//    i_start has priority over i_rx_valid in the same cycle, and that byte is dropped.
//  - IDLE/DONE/ERROR: i_rx_valid is ignored; no writes happen.
//  - RECV: on each i_rx_valid, word <= {word[NB_INSTR-NB_BYTE-1:0], i_rx_data} and byte_cnt++.
//    On the 4th byte, go to WRITE; byte_cnt wraps to 0.
//  - WRITE (exactly 1 cycle): write_enb=1 with addr/data registered, so the write comes
//    1 cycle after the 4th i_rx_valid. Then word_count++ and addr++.
//    data==HALT_INSTR -> DONE; else addr==N_WORDS-1 -> ERROR; else -> RECV.
//  - An i_rx_valid during WRITE is taken as byte 0 of the next word; no byte is lost.
//  - o_done is high only in DONE; o_overflow is high only in ERROR. Both hold until
//    i_start or reset. o_busy is low in IDLE, DONE and ERROR.
//  - Address never exceeds N_WORDS-1; no write is issued once in ERROR.
//  - A partial word (fewer than 4 bytes) is never written.
// STRUCTURE
//  - Shared package/include: NB_INSTR, NB_BYTE, HALT_INSTR, and the state encodings
//    (also used by the debug unit that sequences loads).
//  - One sub-module, byte_word_packer: shift register plus 2-bit byte counter; outputs
//    word and word_valid. The FSM, address counter and counters stay in the top module.
// TESTING
//  1 Reset: assert i_rst for 2 cycles -> all outputs 0, no write pulse.
//  2 Normal load: start; bytes 20 01 00 05, then FF FF FF FF -> write addr0=0x20010005 and
//    addr1=0xFFFFFFFF, each 1 cycle after its 4th byte; then o_done=1, o_word_count=2, o_busy=0.
//  3 Bytes with no i_start (IDLE) and bytes after DONE -> no o_instruction_write_enb pulse.
//  4 N_WORDS=4 override, 4 non-HALT words -> writes to addr 0..3; then o_overflow=1,
//    o_busy=0, and a 5th word gives no write.
//  5 Restart: bytes 11 22, then i_start, then AA BB CC DD -> single write addr0=0xAABBCCDD.
//  6 Back-to-back: 4th byte of word0 followed by byte 0 of word1 in the WRITE cycle ->
//    word1 assembled correctly. Also: reset mid-load, then a new load writes from addr 0.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the debug unit that sequences loads.
//   NB_BYTE    : width of one received UART byte
//   NB_INSTR   : instruction width, always 4 bytes
//   HALT_INSTR : end-of-program word; written to memory, then the load ends
//   state_e    : loader FSM encoding, also decoded by the debug unit
package instruction_loader_pkg;

  localparam int unsigned NB_BYTE = 8;
  localparam int unsigned NB_INSTR = 4 * NB_BYTE;
  localparam logic [NB_INSTR-1:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRecv  = 3'd1,
    StWrite = 3'd2,
    StDone  = 3'd3,
    StError = 3'd4
  } state_e;

endpackage

// File: rtl/instruction_loader_byte_word_packer.sv
// Packs bytes MSB-first into one instruction word.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clear      : restart packing at byte 0 (new load)
//   i_accept     : i_rx_data is taken into the shift register this cycle
//   i_rx_data    : received byte
//   o_word       : shift register contents; holds a full word the cycle after the 4th byte
//   o_word_valid : the byte accepted this cycle completes a word
module instruction_loader_byte_word_packer #(
  parameter int unsigned NB_BYTE  = 8,
  parameter int unsigned NB_INSTR = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_accept,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  output logic [NB_INSTR-1:0] o_word,
  output logic                o_word_valid
);

  logic [NB_INSTR-1:0] word_q, word_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;

  always_comb begin
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    if (i_clear) begin
      word_d     = '0;
      byte_cnt_d = 2'd0;
    end else if (i_accept) begin
      word_d     = {word_q[NB_INSTR-NB_BYTE-1:0], i_rx_data};
      // Two-bit counter wraps to 0 on the 4th byte by itself.
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_q     <= '0;
      byte_cnt_q <= 2'd0;
    end else begin
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = i_accept && !i_clear && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Writer side of the instruction-memory load port. Packs the debug UART byte stream into
// 32-bit instructions and writes them to consecutive word addresses until HALT is written.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_start                 : pulse; begin or restart a load at address 0
//   i_rx_data, i_rx_valid   : received byte and its strobe
//   o_instruction_write_enb : 1-cycle write pulse per word
//   o_instruction_addr      : write word address
//   o_instruction_data      : write data
//   o_busy                  : load in progress (pipeline held)
//   o_done                  : HALT written; holds until start/reset
//   o_overflow              : memory filled without HALT; holds until start/reset
//   o_word_count            : words written in this load, HALT included
module instruction_loader
  import instruction_loader_pkg::state_e,
         instruction_loader_pkg::StIdle,
         instruction_loader_pkg::StRecv,
         instruction_loader_pkg::StWrite,
         instruction_loader_pkg::StDone,
         instruction_loader_pkg::StError;
#(
  parameter int unsigned          NB_BYTE    = instruction_loader_pkg::NB_BYTE,
  parameter int unsigned          NB_INSTR   = instruction_loader_pkg::NB_INSTR,
  parameter int unsigned          NB_PC      = 32,
  parameter int unsigned          N_WORDS    = 1024,
  parameter logic [NB_INSTR-1:0]  HALT_INSTR = instruction_loader_pkg::HALT_INSTR
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_instruction_write_enb,
  output logic [NB_PC-1:0]    o_instruction_addr,
  output logic [NB_INSTR-1:0] o_instruction_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_overflow,
  output logic [NB_PC-1:0]    o_word_count
);

  localparam logic [NB_PC-1:0] LastAddr = NB_PC'(N_WORDS - 1);

  state_e              state_q, state_d;
  logic [NB_PC-1:0]    addr_q, addr_d;
  logic [NB_PC-1:0]    word_count_q, word_count_d;
  logic                accept;
  logic [NB_INSTR-1:0] word;
  logic                word_valid;

  // A byte arriving in the WRITE cycle is the first byte of the next word. A start in the
  // same cycle wins and the byte is dropped.
  assign accept = i_rx_valid && !i_start && ((state_q == StRecv) || (state_q == StWrite));

  instruction_loader_byte_word_packer #(
    .NB_BYTE  (NB_BYTE),
    .NB_INSTR (NB_INSTR)
  ) u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_start),
    .i_accept     (accept),
    .i_rx_data    (i_rx_data),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    if (i_start) begin
      state_d      = StRecv;
      addr_d       = '0;
      word_count_d = '0;
    end else begin
      case (state_q)
        StRecv: begin
          if (word_valid) state_d = StWrite;
        end
        StWrite: begin
          word_count_d = word_count_q + 1'b1;
          if (word == HALT_INSTR) begin
            state_d = StDone;
          end else if (addr_q == LastAddr) begin
            // Address is left at the last word so it never points past the memory.
            state_d = StError;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StRecv;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
    end
  end

  // Address and data are both flops, stable for the whole WRITE cycle.
  assign o_instruction_write_enb = (state_q == StWrite);
  assign o_instruction_addr      = addr_q;
  assign o_instruction_data      = word;
  assign o_busy                  = (state_q == StRecv) || (state_q == StWrite);
  assign o_done                  = (state_q == StDone);
  assign o_overflow              = (state_q == StError);
  assign o_word_count            = word_count_q;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;

  logic        we, busy, done, overflow;
  logic [31:0] addr, data, wc;
  logic        we4, busy4, done4, overflow4;
  logic [31:0] addr4, data4, wc4;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int wr_cnt4 = 0;
  int snap;
  int snap4;

  always #5 clk = ~clk;

  instruction_loader dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_start                 (start),
    .i_rx_data               (rx_data),
    .i_rx_valid              (rx_valid),
    .o_instruction_write_enb (we),
    .o_instruction_addr      (addr),
    .o_instruction_data      (data),
    .o_busy                  (busy),
    .o_done                  (done),
    .o_overflow              (overflow),
    .o_word_count            (wc)
  );

  instruction_loader #(
    .N_WORDS (4)
  ) dut4 (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_start                 (start),
    .i_rx_data               (rx_data),
    .i_rx_valid              (rx_valid),
    .o_instruction_write_enb (we4),
    .o_instruction_addr      (addr4),
    .o_instruction_data      (data4),
    .o_busy                  (busy4),
    .o_done                  (done4),
    .o_overflow              (overflow4),
    .o_word_count            (wc4)
  );

  always @(negedge clk) begin
    if (we) wr_cnt <= wr_cnt + 1;
    if (we4) wr_cnt4 <= wr_cnt4 + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One cycle of stimulus; returns 1ns after the edge that sampled it.
  task automatic drive(input logic s, input logic v, input logic [7:0] d);
    start    = s;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 3; i >= 0; i--) drive(1'b0, 1'b1, t[i*8 +: 8]);
  endtask

  initial begin
    // 1: reset
    @(posedge clk); #1;
    check_eq("rst_we", {31'd0, we}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_addr", addr, 32'd0);
    check_eq("rst_data", data, 32'd0);
    check_eq("rst_flags", {28'd0, we, busy, done, overflow}, 32'd0);
    check_eq("rst_wc", wc, 32'd0);
    check_eq("rst_flags4", {28'd0, we4, busy4, done4, overflow4}, 32'd0);

    // 3a: bytes in IDLE give no write
    send_word(32'h1234_5678);
    drive(1'b0, 1'b0, 8'h00);
    check_eq("idle_nowrite", wr_cnt, 0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);

    // 2: normal load
    drive(1'b1, 1'b0, 8'h00);
    check_eq("start_busy", {31'd0, busy}, 32'd1);
    send_word(32'h2001_0005);
    check_eq("w0_we", {31'd0, we}, 32'd1);
    check_eq("w0_addr", addr, 32'd0);
    check_eq("w0_data", data, 32'h2001_0005);
    drive(1'b0, 1'b0, 8'h00);
    check_eq("w0_we_low", {31'd0, we}, 32'd0);
    send_word(32'hFFFF_FFFF);
    check_eq("halt_we", {31'd0, we}, 32'd1);
    check_eq("halt_addr", addr, 32'd1);
    check_eq("halt_data", data, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 8'h00);
    check_eq("done", {31'd0, done}, 32'd1);
    check_eq("done_busy", {31'd0, busy}, 32'd0);
    check_eq("done_wc", wc, 32'd2);
    check_eq("done4", {31'd0, done4}, 32'd1);

    // 3b: bytes after DONE give no write
    snap = wr_cnt;
    send_word(32'h0102_0304);
    drive(1'b0, 1'b0, 8'h00);
    check_eq("after_done_nowrite", wr_cnt, snap);
    check_eq("after_done_hold", {31'd0, done}, 32'd1);

    // 4: overflow on the 4-word instance
    drive(1'b1, 1'b0, 8'h00);
    check_eq("start_clr_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_word({8'h10 + 8'(i), 24'h20_3040});
      check_eq("ov_we", {31'd0, we4}, 32'd1);
      check_eq("ov_addr", addr4, 32'(i));
      check_eq("ov_data", data4, {8'h10 + 8'(i), 24'h20_3040});
      drive(1'b0, 1'b0, 8'h00);
    end
    check_eq("ov_flag", {31'd0, overflow4}, 32'd1);
    check_eq("ov_busy", {31'd0, busy4}, 32'd0);
    check_eq("ov_wc", wc4, 32'd4);
    check_eq("ov_addr_cap", addr4, 32'd3);
    check_eq("big_no_ov", {30'd0, overflow, busy}, 32'd1);
    snap4 = wr_cnt4;
    send_word(32'h5555_AAAA);
    check_eq("ov5_we4", {31'd0, we4}, 32'd0);
    check_eq("big_w4_we", {31'd0, we}, 32'd1);
    check_eq("big_w4_addr", addr, 32'd4);
    drive(1'b0, 1'b0, 8'h00);
    check_eq("ov5_nowrite", wr_cnt4, snap4);
    check_eq("ov_hold", {31'd0, overflow4}, 32'd1);

    // 5: restart mid-word; start with a simultaneous byte drops that byte
    snap = wr_cnt;
    drive(1'b1, 1'b0, 8'h00);
    check_eq("start_clr_ov", {31'd0, overflow4}, 32'd0);
    drive(1'b0, 1'b1, 8'h11);
    drive(1'b0, 1'b1, 8'h22);
    drive(1'b1, 1'b1, 8'h99);
    send_word(32'hAABB_CCDD);
    check_eq("rs_we", {31'd0, we}, 32'd1);
    check_eq("rs_addr", addr, 32'd0);
    check_eq("rs_data", data, 32'hAABB_CCDD);
    drive(1'b0, 1'b0, 8'h00);
    check_eq("rs_single", wr_cnt - snap, 1);
    check_eq("rs_wc", wc, 32'd1);

    // 6: back-to-back words, byte 0 of word 1 arrives in the WRITE cycle
    drive(1'b1, 1'b0, 8'h00);
    send_word(32'h0102_0304);
    check_eq("b2b_w0_we", {31'd0, we}, 32'd1);
    check_eq("b2b_w0_data", data, 32'h0102_0304);
    send_word(32'h0506_0708);
    check_eq("b2b_w1_we", {31'd0, we}, 32'd1);
    check_eq("b2b_w1_addr", addr, 32'd1);
    check_eq("b2b_w1_data", data, 32'h0506_0708);
    drive(1'b0, 1'b0, 8'h00);
    check_eq("b2b_wc", wc, 32'd2);

    // 6b: reset mid-load, then a fresh load writes from address 0
    drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b1, 8'h02);
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_addr", addr, 32'd0);
    check_eq("mid_rst_wc", wc, 32'd0);
    drive(1'b1, 1'b0, 8'h00);
    send_word(32'hDEAD_BEEF);
    check_eq("mid_rst_we", {31'd0, we}, 32'd1);
    check_eq("mid_rst_waddr", addr, 32'd0);
    check_eq("mid_rst_data", data, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 8'h00);
    check_eq("mid_rst_wc1", wc, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
